// File: rtl/id_ex_pipe_p.sv
// ID/EX pipeline register stage: decodes the fetched instruction (class code,
// immediate, illegal flag), reads operands with an optional write-back
// bypass, inserts load-use bubbles and honours flush and EX backpressure.
// All state updates on the falling edge of clk2.
module id_ex_pipe_p #(
  parameter int XLEN      = 32,
  parameter int HAZARD_EN = 1,
  parameter int WB_BYPASS = 1
) (
  input  logic            clk2,
  input  logic            rst_n,
  input  logic            if_id_valid,
  output logic            if_id_ready,
  input  logic [31:0]     IF_ID_IR,
  input  logic [XLEN-1:0] IF_ID_NPC,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            cond_stage,
  input  logic            ex_ready,
  output logic            ID_EX_valid,
  output logic [31:0]     ID_EX_IR,
  output logic [XLEN-1:0] ID_EX_NPC,
  output logic [XLEN-1:0] ID_EX_imm,
  output logic [XLEN-1:0] ID_EX_rs1,
  output logic [XLEN-1:0] ID_EX_rs2,
  output logic [4:0]      ID_EX_rd,
  output logic [2:0]      ID_EX_type,
  output logic            ID_EX_illegal
);

  localparam logic [2:0] T_I_LOAD  = 3'b000;
  localparam logic [2:0] T_I_LOGIC = 3'b001;
  localparam logic [2:0] T_S       = 3'b010;
  localparam logic [2:0] T_R       = 3'b011;
  localparam logic [2:0] T_J       = 3'b100;
  localparam logic [2:0] T_U       = 3'b101;
  localparam logic [2:0] T_I_JUMP  = 3'b110;
  localparam logic [2:0] T_B       = 3'b111;

  logic [6:0]      opcode;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u;
  logic [2:0]      dec_type;
  logic [XLEN-1:0] dec_imm;
  logic            dec_illegal;
  logic            uses_rs1, uses_rs2;
  logic            load_use;
  logic            load_en;
  logic [XLEN-1:0] rs1_val, rs2_val;

  assign opcode   = IF_ID_IR[6:0];
  assign rs1_addr = IF_ID_IR[19:15];
  assign rs2_addr = IF_ID_IR[24:20];

  // Signed-to-wider casts sign-extend from IR[31] for any XLEN.
  assign imm_i = XLEN'($signed(IF_ID_IR[31:20]));
  assign imm_s = XLEN'($signed({IF_ID_IR[31:25], IF_ID_IR[11:7]}));
  assign imm_b = XLEN'($signed({IF_ID_IR[31], IF_ID_IR[7], IF_ID_IR[30:25],
                                IF_ID_IR[11:8], 1'b0}));
  assign imm_j = XLEN'($signed({IF_ID_IR[31], IF_ID_IR[19:12], IF_ID_IR[20],
                                IF_ID_IR[30:21], 1'b0}));
  assign imm_u = XLEN'($signed({IF_ID_IR[31:12], 12'b0}));

  // Opcode to class code and immediate; unknown opcodes decode as an
  // illegal I_logic with a zero immediate so nothing downstream sees X.
  always_comb begin
    dec_type    = T_I_LOGIC;
    dec_imm     = '0;
    dec_illegal = 1'b0;
    case (opcode)
      7'b0110011: dec_type = T_R;
      7'b0010011,
      7'b1110011: begin dec_type = T_I_LOGIC; dec_imm = imm_i; end
      7'b0000011: begin dec_type = T_I_LOAD;  dec_imm = imm_i; end
      7'b1100111: begin dec_type = T_I_JUMP;  dec_imm = imm_i; end
      7'b0100011: begin dec_type = T_S;       dec_imm = imm_s; end
      7'b1100011: begin dec_type = T_B;       dec_imm = imm_b; end
      7'b1101111: begin dec_type = T_J;       dec_imm = imm_j; end
      7'b0010111,
      7'b0110111: begin dec_type = T_U;       dec_imm = imm_u; end
      default:    dec_illegal = 1'b1;
    endcase
  end

  // Which source fields the incoming instruction really reads.
  assign uses_rs1 = (dec_type != T_J) && (dec_type != T_U);
  assign uses_rs2 = (dec_type == T_R) || (dec_type == T_S) || (dec_type == T_B);

  // A load in ID_EX whose result is needed by the incoming instruction.
  assign load_use = (HAZARD_EN != 0) && ID_EX_valid && (ID_EX_type == T_I_LOAD) &&
                    (ID_EX_rd != 5'd0) && if_id_valid &&
                    (((ID_EX_rd == rs1_addr) && uses_rs1) ||
                     ((ID_EX_rd == rs2_addr) && uses_rs2));

  assign if_id_ready = (!ID_EX_valid || ex_ready) && !load_use;
  assign load_en     = if_id_valid && if_id_ready;

  // Write-back bypass so a value written this cycle is not missed; x0 never.
  assign rs1_val = ((WB_BYPASS != 0) && wb_we && (wb_rd != 5'd0) && (wb_rd == rs1_addr))
                   ? wb_data : rs1;
  assign rs2_val = ((WB_BYPASS != 0) && wb_we && (wb_rd != 5'd0) && (wb_rd == rs2_addr))
                   ? wb_data : rs2;

  // Stage register: reset > flush > load > hold > bubble. A bubble leaves
  // NPC and operand registers untouched since they are meaningless when invalid.
  always_ff @(negedge clk2) begin
    if (!rst_n) begin
      ID_EX_valid   <= 1'b0;
      ID_EX_IR      <= '0;
      ID_EX_NPC     <= '0;
      ID_EX_imm     <= '0;
      ID_EX_rs1     <= '0;
      ID_EX_rs2     <= '0;
      ID_EX_rd      <= '0;
      ID_EX_type    <= T_I_LOGIC;
      ID_EX_illegal <= 1'b0;
    end else if (!cond_stage && load_en) begin
      ID_EX_valid   <= 1'b1;
      ID_EX_IR      <= IF_ID_IR;
      ID_EX_NPC     <= IF_ID_NPC;
      ID_EX_imm     <= dec_imm;
      ID_EX_rs1     <= rs1_val;
      ID_EX_rs2     <= rs2_val;
      ID_EX_rd      <= IF_ID_IR[11:7];
      ID_EX_type    <= dec_type;
      ID_EX_illegal <= dec_illegal;
    end else if (!cond_stage && ID_EX_valid && !ex_ready) begin
      ID_EX_valid   <= ID_EX_valid;
    end else begin
      ID_EX_valid   <= 1'b0;
      ID_EX_IR      <= '0;
      ID_EX_imm     <= '0;
      ID_EX_rd      <= '0;
      ID_EX_type    <= T_I_LOGIC;
      ID_EX_illegal <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_ex_pipe_p.sv
// Directed bench for id_ex_pipe_p: decode, load-use, backpressure, flush,
// bypass, reset and a 64-bit instance.
module tb_id_ex_pipe_p;

  logic clk2 = 1'b1;
  always #5 clk2 = ~clk2;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  logic        rst_n, if_id_valid, wb_we, cond_stage, ex_ready;
  logic [31:0] IF_ID_IR, IF_ID_NPC, rs1, rs2, wb_data;
  logic [4:0]  wb_rd;

  logic        if_id_ready, ID_EX_valid, ID_EX_illegal;
  logic [4:0]  rs1_addr, rs2_addr, ID_EX_rd;
  logic [31:0] ID_EX_IR, ID_EX_NPC, ID_EX_imm, ID_EX_rs1, ID_EX_rs2;
  logic [2:0]  ID_EX_type;

  logic [63:0] npc64, rs1_64, rs2_64, wb_data64;
  logic        w_ready, w_valid, w_illegal;
  logic [4:0]  w_rs1_addr, w_rs2_addr, w_rd;
  logic [31:0] w_ir;
  logic [63:0] w_npc, w_imm, w_rs1, w_rs2;
  logic [2:0]  w_type;

  id_ex_pipe_p dut (
    .clk2(clk2), .rst_n(rst_n), .if_id_valid(if_id_valid), .if_id_ready(if_id_ready),
    .IF_ID_IR(IF_ID_IR), .IF_ID_NPC(IF_ID_NPC), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1(rs1), .rs2(rs2), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .cond_stage(cond_stage), .ex_ready(ex_ready), .ID_EX_valid(ID_EX_valid),
    .ID_EX_IR(ID_EX_IR), .ID_EX_NPC(ID_EX_NPC), .ID_EX_imm(ID_EX_imm),
    .ID_EX_rs1(ID_EX_rs1), .ID_EX_rs2(ID_EX_rs2), .ID_EX_rd(ID_EX_rd),
    .ID_EX_type(ID_EX_type), .ID_EX_illegal(ID_EX_illegal)
  );

  id_ex_pipe_p #(.XLEN(64)) dut64 (
    .clk2(clk2), .rst_n(rst_n), .if_id_valid(if_id_valid), .if_id_ready(w_ready),
    .IF_ID_IR(IF_ID_IR), .IF_ID_NPC(npc64), .rs1_addr(w_rs1_addr), .rs2_addr(w_rs2_addr),
    .rs1(rs1_64), .rs2(rs2_64), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data64),
    .cond_stage(cond_stage), .ex_ready(ex_ready), .ID_EX_valid(w_valid),
    .ID_EX_IR(w_ir), .ID_EX_NPC(w_npc), .ID_EX_imm(w_imm),
    .ID_EX_rs1(w_rs1), .ID_EX_rs2(w_rs2), .ID_EX_rd(w_rd),
    .ID_EX_type(w_type), .ID_EX_illegal(w_illegal)
  );

  // One falling edge, then settle; prints one line per transaction.
  task automatic tick();
    @(negedge clk2);
    #1;
    cycle++;
    $display("cycle %0d: IR_in=%08h v_in=%0b ex_rdy=%0b flush=%0b -> valid=%0b IR=%08h type=%03b imm=%08h rd=%0d ill=%0b ready=%0b",
             cycle, IF_ID_IR, if_id_valid, ex_ready, cond_stage, ID_EX_valid, ID_EX_IR,
             ID_EX_type, ID_EX_imm, ID_EX_rd, ID_EX_illegal, if_id_ready);
  endtask

  // Drain the stage so each scenario starts from an empty ID_EX.
  task automatic idle();
    if_id_valid = 1'b0; ex_ready = 1'b1; cond_stage = 1'b0; wb_we = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; if_id_valid = 1'b1; IF_ID_IR = 32'h00728333; ex_ready = 1'b1;
    cond_stage = 1'b1;
    tick();
    checks++; if (ID_EX_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", ID_EX_valid); end
    checks++; if (ID_EX_IR !== 32'h0) begin errors++; $display("FAIL reset_ir: got %08h want 00000000", ID_EX_IR); end
    checks++; if (ID_EX_type !== 3'b001) begin errors++; $display("FAIL reset_type: got %03b want 001", ID_EX_type); end
    checks++; if ({ID_EX_NPC, ID_EX_imm, ID_EX_rs1, ID_EX_rs2} !== 128'h0) begin errors++; $display("FAIL reset_data: npc=%08h imm=%08h rs1=%08h rs2=%08h want 0", ID_EX_NPC, ID_EX_imm, ID_EX_rs1, ID_EX_rs2); end
    checks++; if ({ID_EX_rd, ID_EX_illegal} !== 6'h0) begin errors++; $display("FAIL reset_rd_ill: rd=%0d ill=%0b want 0", ID_EX_rd, ID_EX_illegal); end
    rst_n = 1'b1; cond_stage = 1'b0; if_id_valid = 1'b0;
    #1;
    checks++; if (if_id_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b want 1", if_id_ready); end
  endtask

  task automatic test_decode();
    logic [31:0] ir_v  [9] = '{32'hFE010EE3, 32'h123452B7, 32'hFFF00093, 32'h00512423,
                               32'h001000EF, 32'h004100E7, 32'h00728333, 32'hFFFFFFFF,
                               32'h0000A283};
    logic [2:0]  ty_v  [9] = '{3'b111, 3'b101, 3'b001, 3'b010, 3'b100, 3'b110, 3'b011,
                               3'b001, 3'b000};
    logic [31:0] imm_v [9] = '{32'hFFFFFFFC, 32'h12345000, 32'hFFFFFFFF, 32'h00000008,
                               32'h00000800, 32'h00000004, 32'h00000000, 32'h00000000,
                               32'h00000000};
    logic [4:0]  rd_v  [9] = '{5'd29, 5'd5, 5'd1, 5'd8, 5'd1, 5'd1, 5'd6, 5'd31, 5'd5};
    logic        ill_v [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    idle();
    for (int i = 0; i < 9; i++) begin
      if_id_valid = 1'b1; ex_ready = 1'b1;
      IF_ID_IR = ir_v[i]; IF_ID_NPC = 32'h1000 + 32'(4 * i);
      tick();
      checks++; if (ID_EX_valid !== 1'b1 || ID_EX_IR !== ir_v[i]) begin errors++; $display("FAIL decode_load[%0d]: valid=%0b IR=%08h want 1 %08h", i, ID_EX_valid, ID_EX_IR, ir_v[i]); end
      checks++; if (ID_EX_type !== ty_v[i]) begin errors++; $display("FAIL decode_type[%0d]: got %03b want %03b", i, ID_EX_type, ty_v[i]); end
      checks++; if (ID_EX_imm !== imm_v[i]) begin errors++; $display("FAIL decode_imm[%0d]: got %08h want %08h", i, ID_EX_imm, imm_v[i]); end
      checks++; if (ID_EX_rd !== rd_v[i] || ID_EX_illegal !== ill_v[i]) begin errors++; $display("FAIL decode_rd_ill[%0d]: rd=%0d ill=%0b want %0d %0b", i, ID_EX_rd, ID_EX_illegal, rd_v[i], ill_v[i]); end
      checks++; if (ID_EX_NPC !== 32'h1000 + 32'(4 * i)) begin errors++; $display("FAIL decode_npc[%0d]: got %08h want %08h", i, ID_EX_NPC, 32'h1000 + 32'(4 * i)); end
    end
  endtask

  task automatic test_load_use();
    idle();
    if_id_valid = 1'b1; ex_ready = 1'b1; IF_ID_IR = 32'h0000A283;   // lw x5
    tick();
    IF_ID_IR = 32'h00728333;                                       // add x6,x5,x7
    #1;
    checks++; if (rs1_addr !== 5'd5 || rs2_addr !== 5'd7) begin errors++; $display("FAIL lu_addrs: rs1=%0d rs2=%0d want 5 7", rs1_addr, rs2_addr); end
    checks++; if (if_id_ready !== 1'b0) begin errors++; $display("FAIL lu_ready_low: got %0b want 0", if_id_ready); end
    tick();
    checks++; if (ID_EX_valid !== 1'b0 || ID_EX_IR !== 32'h0) begin errors++; $display("FAIL lu_bubble: valid=%0b IR=%08h want 0 00000000", ID_EX_valid, ID_EX_IR); end
    checks++; if (if_id_ready !== 1'b1) begin errors++; $display("FAIL lu_ready_after: got %0b want 1", if_id_ready); end
    tick();
    checks++; if (ID_EX_valid !== 1'b1 || ID_EX_IR !== 32'h00728333) begin errors++; $display("FAIL lu_add_enters: valid=%0b IR=%08h want 1 00728333", ID_EX_valid, ID_EX_IR); end
    IF_ID_IR = 32'h0000A003;                                       // lw x0
    tick();
    IF_ID_IR = 32'h00700333;                                       // add x6,x0,x7
    #1;
    checks++; if (if_id_ready !== 1'b1) begin errors++; $display("FAIL lu_x0_ready: got %0b want 1", if_id_ready); end
    tick();
    checks++; if (ID_EX_valid !== 1'b1 || ID_EX_IR !== 32'h00700333) begin errors++; $display("FAIL lu_x0_nobubble: valid=%0b IR=%08h want 1 00700333", ID_EX_valid, ID_EX_IR); end
    IF_ID_IR = 32'h0000A383;                                       // lw x7
    tick();
    IF_ID_IR = 32'h00728333;                                       // add reads x7 as rs2
    #1;
    checks++; if (if_id_ready !== 1'b0) begin errors++; $display("FAIL lu_rs2_ready: got %0b want 0", if_id_ready); end
    IF_ID_IR = 32'h00700093;                                       // addi x1,x0,7: field 24:20=7 but not read
    #1;
    checks++; if (if_id_ready !== 1'b1) begin errors++; $display("FAIL lu_itype_rs2: got %0b want 1", if_id_ready); end
  endtask

  task automatic test_backpressure();
    idle();
    if_id_valid = 1'b1; ex_ready = 1'b1; IF_ID_IR = 32'hFFF00093;
    tick();
    IF_ID_IR = 32'h00728333; ex_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (if_id_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d]: got %0b want 0", i, if_id_ready); end
      tick();
      checks++; if (ID_EX_valid !== 1'b1 || ID_EX_IR !== 32'hFFF00093 || ID_EX_imm !== 32'hFFFFFFFF) begin errors++; $display("FAIL bp_hold[%0d]: valid=%0b IR=%08h imm=%08h want 1 FFF00093 FFFFFFFF", i, ID_EX_valid, ID_EX_IR, ID_EX_imm); end
    end
    ex_ready = 1'b1;
    #1;
    checks++; if (if_id_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %0b want 1", if_id_ready); end
    tick();
    checks++; if (ID_EX_IR !== 32'h00728333 || ID_EX_type !== 3'b011) begin errors++; $display("FAIL bp_next_load: IR=%08h type=%03b want 00728333 011", ID_EX_IR, ID_EX_type); end
    if_id_valid = 1'b0;
    tick();
    checks++; if ({ID_EX_valid, ID_EX_IR, ID_EX_imm, ID_EX_type, ID_EX_rd, ID_EX_illegal} !== {1'b0, 32'h0, 32'h0, 3'b001, 5'd0, 1'b0}) begin errors++; $display("FAIL bp_drain_bubble: valid=%0b IR=%08h imm=%08h type=%03b rd=%0d ill=%0b", ID_EX_valid, ID_EX_IR, ID_EX_imm, ID_EX_type, ID_EX_rd, ID_EX_illegal); end
  endtask

  task automatic test_flush();
    idle();
    if_id_valid = 1'b1; ex_ready = 1'b1; IF_ID_IR = 32'h0000A283;
    tick();
    IF_ID_IR = 32'h00728333; ex_ready = 1'b0; cond_stage = 1'b1;
    tick();
    checks++; if (ID_EX_valid !== 1'b0 || ID_EX_IR !== 32'h0) begin errors++; $display("FAIL flush_over_hold: valid=%0b IR=%08h want 0 00000000", ID_EX_valid, ID_EX_IR); end
    ex_ready = 1'b1; IF_ID_IR = 32'hFFF00093;
    #1;
    checks++; if (if_id_ready !== 1'b1) begin errors++; $display("FAIL flush_ready_ungated: got %0b want 1", if_id_ready); end
    tick();
    checks++; if (ID_EX_valid !== 1'b0 || ID_EX_IR !== 32'h0 || ID_EX_type !== 3'b001) begin errors++; $display("FAIL flush_over_load: valid=%0b IR=%08h type=%03b want 0 00000000 001", ID_EX_valid, ID_EX_IR, ID_EX_type); end
    cond_stage = 1'b0;
  endtask

  task automatic test_bypass();
    idle();
    if_id_valid = 1'b1; ex_ready = 1'b1;
    wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEADBEEF; rs1 = 32'h0; rs2 = 32'h55;
    IF_ID_IR = 32'h00018093;                                       // addi x1,x3,0
    tick();
    checks++; if (ID_EX_rs1 !== 32'hDEADBEEF) begin errors++; $display("FAIL byp_rs1: got %08h want DEADBEEF", ID_EX_rs1); end
    wb_rd = 5'd0; rs1 = 32'h12345678;
    tick();
    checks++; if (ID_EX_rs1 !== 32'h12345678) begin errors++; $display("FAIL byp_rd0_rs1: got %08h want 12345678", ID_EX_rs1); end
    wb_rd = 5'd3; IF_ID_IR = 32'h003000B3;                         // add x1,x0,x3
    tick();
    checks++; if (ID_EX_rs2 !== 32'hDEADBEEF || ID_EX_rs1 !== 32'h12345678) begin errors++; $display("FAIL byp_rs2: rs2=%08h rs1=%08h want DEADBEEF 12345678", ID_EX_rs2, ID_EX_rs1); end
    wb_rd = 5'd0; rs1 = 32'h0000A5A5; IF_ID_IR = 32'h00000093;     // addi x1,x0,0
    tick();
    checks++; if (ID_EX_rs1 !== 32'h0000A5A5) begin errors++; $display("FAIL byp_x0: got %08h want 0000A5A5", ID_EX_rs1); end
    wb_we = 1'b0; wb_rd = 5'd3; rs1 = 32'h77; IF_ID_IR = 32'h00018093;
    tick();
    checks++; if (ID_EX_rs1 !== 32'h77) begin errors++; $display("FAIL byp_we0: got %08h want 00000077", ID_EX_rs1); end
  endtask

  task automatic test_reset_mid_hold();
    idle();
    if_id_valid = 1'b1; ex_ready = 1'b1; IF_ID_IR = 32'h0000A283; IF_ID_NPC = 32'h2000;
    tick();
    IF_ID_IR = 32'h00728333; ex_ready = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    checks++; if (ID_EX_valid !== 1'b0 || ID_EX_IR !== 32'h0 || ID_EX_NPC !== 32'h0 || ID_EX_type !== 3'b001) begin errors++; $display("FAIL rst_hold_clear: valid=%0b IR=%08h npc=%08h type=%03b", ID_EX_valid, ID_EX_IR, ID_EX_NPC, ID_EX_type); end
    rst_n = 1'b1;
    #1;
    checks++; if (if_id_ready !== 1'b1) begin errors++; $display("FAIL rst_hold_ready: got %0b want 1", if_id_ready); end
  endtask

  task automatic test_xlen64();
    idle();
    if_id_valid = 1'b1; ex_ready = 1'b1; npc64 = 64'h0000_0001_0000_0004;
    rs1_64 = 64'h1111_2222_3333_4444; rs2_64 = 64'h5;
    IF_ID_IR = 32'h80000093;                                       // addi x1,x0,-2048
    tick();
    checks++; if (w_imm !== 64'hFFFFFFFFFFFFF800 || w_type !== 3'b001) begin errors++; $display("FAIL x64_addi: imm=%016h type=%03b want FFFFFFFFFFFFF800 001", w_imm, w_type); end
    checks++; if (w_npc !== 64'h0000_0001_0000_0004 || w_rs1 !== 64'h1111_2222_3333_4444) begin errors++; $display("FAIL x64_data: npc=%016h rs1=%016h", w_npc, w_rs1); end
    IF_ID_IR = 32'h0000007F;
    tick();
    checks++; if (w_illegal !== 1'b1 || w_imm !== 64'h0 || w_type !== 3'b001) begin errors++; $display("FAIL x64_illegal: ill=%0b imm=%016h type=%03b want 1 0 001", w_illegal, w_imm, w_type); end
    checks++; if ((^{w_ready, w_valid, w_illegal, w_rs1_addr, w_rs2_addr, w_rd, w_ir, w_npc, w_imm, w_rs1, w_rs2, w_type}) === 1'bx) begin errors++; $display("FAIL x64_no_x: outputs carry X, imm=%016h ir=%08h", w_imm, w_ir); end
  endtask

  initial begin
    rst_n = 1'b0; if_id_valid = 1'b0; IF_ID_IR = '0; IF_ID_NPC = '0;
    rs1 = '0; rs2 = '0; wb_we = 1'b0; wb_rd = '0; wb_data = '0;
    cond_stage = 1'b0; ex_ready = 1'b1;
    npc64 = '0; rs1_64 = '0; rs2_64 = '0; wb_data64 = '0;
    #1;
    test_reset();
    test_decode();
    test_load_use();
    test_backpressure();
    test_flush();
    test_bypass();
    test_reset_mid_hold();
    test_xlen64();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_pipe_p.md
ID_EX_PIPE_P -- requirements
Module: id_ex_pipe_p

Interface
REQ-001 SHALL provide parameters: XLEN, default 32, datapath width (32 or 64); HAZARD_EN, default 1, enables load-use bubble insertion; WB_BYPASS, default 1, enables write-back-to-decode bypass.
REQ-002 SHALL use one clock, clk2; reset is synchronous and active-low, rst_n; all registers update on the falling edge of clk2.
REQ-003 Ports, as name  direction  width  meaning:
  clk2  in  1  stage clock
  rst_n  in  1  synchronous active-low reset
  if_id_valid  in  1  IF_ID_IR/IF_ID_NPC hold a real instruction
  if_id_ready  out  1  stage accepts an instruction this edge
  IF_ID_IR  in  32  fetched instruction
  IF_ID_NPC  in  XLEN  next PC
  rs1_addr  out  5  IF_ID_IR[19:15], combinational
  rs2_addr  out  5  IF_ID_IR[24:20], combinational
  rs1, rs2  in  XLEN  register-file read data
  wb_we  in  1  write-back writes the register file this cycle
  wb_rd  in  5  write-back destination
  wb_data  in  XLEN  write-back value
  cond_stage  in  1  flush (taken branch/jump)
  ex_ready  in  1  EX accepts ID_EX contents
  ID_EX_valid  out  1  ID_EX registers hold a real instruction
  ID_EX_IR  out  32  registered instruction
  ID_EX_NPC, ID_EX_imm, ID_EX_rs1, ID_EX_rs2  out  XLEN  registered NPC, immediate, operands
  ID_EX_rd  out  5  IR[11:7]
  ID_EX_type  out  3  class code
  ID_EX_illegal  out  1  opcode not decodable

Function
REQ-004 Class codes SHALL be: R=011, S=010, B=111, J=100, U=101, I_jump=110, I_logic=001, I_load=000.
REQ-005 Opcode mapping SHALL be: 0110011->R; 0010011->I_logic; 1110011->I_logic; 0000011->I_load; 1100111->I_jump; 0100011->S; 1100011->B; 1101111->J; 0010111, 0110111->U; any other opcode->I_logic with ID_EX_illegal=1 and ID_EX_imm=0.
REQ-006 Immediates SHALL sign-extend from IR[31] to XLEN: I={IR[31:20]}; S={IR[31:25],IR[11:7]}; B={IR[31],IR[7],IR[30:25],IR[11:8],1'b0}; J={IR[31],IR[19:12],IR[20],IR[30:21],1'b0}; U={IR[31:12],12'b0}; R imm=0.
REQ-007 if_id_ready SHALL be (!ID_EX_valid || ex_ready) && !load_use, combinational.
REQ-008 Load: when if_id_valid && if_id_ready, all ID_EX registers SHALL capture decoded values and ID_EX_valid<=1.
REQ-009 Hold: when ID_EX_valid && !ex_ready && !cond_stage, all ID_EX registers SHALL keep their values.
REQ-010 Drain: when (!ID_EX_valid || ex_ready) and no load occurs, the stage SHALL write a bubble: ID_EX_valid=0, ID_EX_IR=0, ID_EX_imm=0, ID_EX_type=I_logic, ID_EX_illegal=0, ID_EX_rd=0.
REQ-011 load_use (only when HAZARD_EN=1) SHALL be ID_EX_valid && ID_EX_type==I_load && ID_EX_rd!=0 && if_id_valid && ((ID_EX_rd==rs1_addr && incoming class in {R,I_*,S,B}) || (ID_EX_rd==rs2_addr && incoming class in {R,S,B})); while asserted and ex_ready=1, a bubble SHALL be written, so exactly one bubble is inserted per load-use pair.
REQ-012 Bypass (only when WB_BYPASS=1): if wb_we && wb_rd!=0 && wb_rd==rs1_addr, ID_EX_rs1 SHALL capture wb_data instead of rs1; same for rs2; x0 is never bypassed.
REQ-013 Flush: cond_stage=1 at an edge SHALL force a bubble (REQ-010), overriding load, hold and load_use; if_id_ready is not gated by cond_stage.
REQ-014 Outputs SHALL never carry X for any opcode, including illegal ones.

Reset
REQ-015 When rst_n=0 at a falling edge of clk2, ID_EX_valid, ID_EX_IR, ID_EX_NPC, ID_EX_imm, ID_EX_rs1, ID_EX_rs2, ID_EX_rd and ID_EX_illegal SHALL clear to 0, and ID_EX_type SHALL be set to I_logic (001); reset overrides flush, hold and load.
REQ-016 Reset asserted mid-hold or mid-stall SHALL discard the held instruction; if_id_ready SHALL equal 1 on the first cycle after reset releases.

Verification
REQ-017 Decode: IR=0xFE010EE3 (beq, negative offset) with ex_ready=1 -> type=111, imm=0xFFFFFFFC, valid=1; IR=0x123452B7 (lui) -> type=101, imm=0x12345000.
REQ-018 Load-use: lw x5 followed by add x6,x5,x7 -> one bubble cycle (valid=0, IR=0) with if_id_ready=0; the add enters on the following edge; for rd=x0 there is no bubble.
REQ-019 Backpressure: valid instruction with ex_ready=0 for 3 cycles -> ID_EX_* stable and if_id_ready=0; the next instruction loads on the edge after ex_ready=1.
REQ-020 Flush priority: cond_stage=1 with a concurrent load_use and ex_ready=0 -> next cycle valid=0, IR=0x00000000.
REQ-021 Bypass: wb_we=1, wb_rd=3, wb_data=0xDEADBEEF, rs1=0, incoming rs1_addr=3 -> ID_EX_rs1=0xDEADBEEF; with wb_rd=0 -> ID_EX_rs1=rs1.
REQ-022 XLEN=64: addi with imm=0x800 -> ID_EX_imm=0xFFFFFFFFFFFFF800; opcode 0x7F -> illegal=1, imm=0, no X on any output.
